// File: rtl/axis_lb_pkg.sv
// Shared types and default sizing for the AXI-Stream loopback sequencer.
package axis_lb_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} lb_state_t;

  localparam int DATA_W_DEF      = 32;
  localparam int LEN_W_DEF       = 16;
  localparam int TIMEOUT_CYC_DEF = 1000000;
  localparam int ERR_W           = 16;
endpackage

// File: rtl/axis_lb_checker.sv
// RX beat checker: compares looped-back beats against seed + index, counts
// accepted beats and mismatches, and flags acceptance of the final beat.
module axis_lb_checker
  import axis_lb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              active,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tready,
  input  logic              s_tlast,
  output logic              err_now,
  output logic              last_acc,
  output logic [ERR_W-1:0]  err_count,
  output logic [LEN_W-1:0]  rx_count
);
  logic              cnt_hs, exp_last;
  logic [DATA_W-1:0] exp_data;

  // rx_count doubles as the beat index; beats past frame_len are drained.
  assign cnt_hs   = active && s_tvalid && s_tready && (rx_count != frame_len);
  assign exp_data = seed + DATA_W'(rx_count);
  assign exp_last = (rx_count == frame_len - LEN_W'(1));
  assign err_now  = cnt_hs && ((s_tdata != exp_data) || (s_tlast != exp_last));
  assign last_acc = cnt_hs && exp_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count <= '0;
      rx_count  <= '0;
    end else if (cnt_hs) begin
      if (rx_count != '1)            rx_count  <= rx_count + LEN_W'(1);
      if (err_now && err_count != '1) err_count <= err_count + ERR_W'(1);
    end
  end
endmodule

// File: rtl/axis_loopback_ctrl.sv
// Loopback test sequencer: sends a counter frame, checks the returned frame,
// and reports pass/fail, error count and timeout/abort status.
module axis_loopback_ctrl
  import axis_lb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pulse,
  input  logic              abort_pulse,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              aborted,
  output logic [ERR_W-1:0]  err_count,
  output logic [LEN_W-1:0]  rx_count
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  lb_state_t         state, state_n;
  logic [LEN_W-1:0]  len_q, tx_idx;
  logic [DATA_W-1:0] seed_q;
  logic [TO_W-1:0]   to_cnt;
  logic              abort_pend, active;
  logic              start_ok, tx_hs, tx_last_hs, rx_hs, rx_full, to_hit;
  logic              err_now, last_acc;
  logic              go_abort, go_timeout, go_pass;

  assign active     = (state == SEND) || (state == WAIT_RX);
  assign start_ok   = start_pulse && !abort_pulse && (frame_len != '0) &&
                      ((state == IDLE) || (state == DONE));
  assign tx_hs      = m_tvalid && m_tready;
  assign tx_last_hs = tx_hs && m_tlast;
  assign rx_hs      = s_tvalid && s_tready;
  assign rx_full    = last_acc || (rx_count == len_q);
  assign to_hit     = (to_cnt == TO_MAX) && !rx_hs;

  axis_lb_checker #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_chk (
    .clk, .rst, .clr(start_ok), .active,
    .seed(seed_q), .frame_len(len_q),
    .s_tdata, .s_tvalid, .s_tready, .s_tlast,
    .err_now, .last_acc, .err_count, .rx_count
  );

  always_comb begin
    state_n    = state;
    go_abort   = 1'b0;
    go_timeout = 1'b0;
    case (state)
      IDLE, DONE: if (start_ok) state_n = SEND;
      SEND: begin
        // A pending abort waits for the in-flight beat to complete.
        if ((abort_pulse || abort_pend) && (!m_tvalid || tx_hs)) begin
          state_n  = DONE;
          go_abort = 1'b1;
        end else if (tx_last_hs) begin
          state_n = rx_full ? DONE : WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (abort_pulse) begin
          state_n  = DONE;
          go_abort = 1'b1;
        end else if (last_acc) begin
          state_n = DONE;
        end else if (to_hit) begin
          state_n    = DONE;
          go_timeout = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    go_pass = (state_n == DONE) && active && !go_abort && !go_timeout &&
              rx_full && (err_count == '0) && !err_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      seed_q     <= '0;
      tx_idx     <= '0;
      to_cnt     <= '0;
      abort_pend <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      s_tready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state    <= state_n;
      s_tready <= 1'b1;
      busy     <= (state_n == SEND) || (state_n == WAIT_RX);
      done     <= (state_n == DONE);
      if (start_ok) begin
        len_q      <= frame_len;
        seed_q     <= seed;
        tx_idx     <= '0;
        to_cnt     <= '0;
        abort_pend <= 1'b0;
        m_tdata    <= seed;
        m_tvalid   <= 1'b1;
        m_tlast    <= (frame_len == LEN_W'(1));
        pass       <= 1'b0;
        timeout    <= 1'b0;
        aborted    <= 1'b0;
      end else begin
        if (state == SEND && state_n != SEND) begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
        end else if (tx_hs) begin
          tx_idx  <= tx_idx + LEN_W'(1);
          m_tdata <= m_tdata + DATA_W'(1);
          m_tlast <= (tx_idx + LEN_W'(1) == len_q - LEN_W'(1));
        end
        abort_pend <= (state == SEND) && (state_n == SEND) && (abort_pend || abort_pulse);
        if (go_abort)   aborted <= 1'b1;
        if (go_timeout) timeout <= 1'b1;
        if (go_pass)    pass    <= 1'b1;
        // Saturating idle counter; only WAIT_RX acts on it.
        if (rx_hs)                      to_cnt <= '0;
        else if (active && to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
endmodule

// File: doc/axis_loopback_ctrl.md
# axis_loopback_ctrl

Sequencer for the stage-1 AXI-Stream loopback test. It is triggered by one-clock command pulses derived from VIO bits upstream. It generates a counter-pattern frame on an AXI-Stream master, receives the looped-back frame on an AXI-Stream slave, checks every beat, and reports pass/fail, error count and timeout status back to the VIO.

## Interface
- DATA_W, 32, tdata width on both streams
- LEN_W, 16, frame length counter width
- TIMEOUT_CYC, 1000000, max idle cycles between RX beats before the run fails
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_pulse  in  1  one-clock start command
- abort_pulse  in  1  one-clock abort command
- frame_len  in  LEN_W  beats per frame, sampled on accepted start
- seed  in  DATA_W  first data word, sampled on accepted start
- m_tdata  out  DATA_W  TX data
- m_tvalid  out  1  TX valid
- m_tready  in  1  TX ready
- m_tlast  out  1  TX last beat
- s_tdata  in  DATA_W  RX data
- s_tvalid  in  1  RX valid
- s_tready  out  1  RX ready
- s_tlast  in  1  RX last
- busy  out  1  run in progress
- done  out  1  run finished; sticky until next accepted start
- pass  out  1  valid only while done=1
- timeout  out  1  run ended by RX timeout
- aborted  out  1  run ended by abort
- err_count  out  16  beat mismatches, saturating at 0xFFFF
- rx_count  out  LEN_W  RX beats accepted this run, saturating

## Operation
- FSM states: IDLE, SEND, WAIT_RX, DONE.
- Start handling:
  - A start is accepted only in IDLE or DONE, and only with frame_len != 0.
  - Otherwise start is ignored; there is no error flag.
  - Accepted start: latch frame_len and seed; clear err_count, rx_count, done, pass, timeout and aborted; go to SEND.
- SEND:
  - Beat k carries tdata = seed + k, mod 2^DATA_W.
  - m_tlast=1 only on beat frame_len-1.
  - tdata, tlast and tvalid hold stable while tvalid && !tready.
  - After the handshake on the last beat, go to WAIT_RX. If that handshake coincides with the final RX beat, go directly to DONE.
- RX checking:
  - s_tready=1 in every state except reset; receiving overlaps SEND.
  - In SEND and WAIT_RX, each RX handshake compares s_tdata against seed + rx_idx.
  - s_tlast must be 1 exactly when rx_idx == frame_len-1.
  - A data mismatch or wrong tlast increments err_count by 1 per beat, even if both are wrong.
  - A run ends on RX when rx_idx reaches frame_len (beat count), whatever tlast says.
  - In IDLE and DONE, RX beats are drained and not counted.
- WAIT_RX:
  - A timeout counter clears on every RX handshake and on entry to SEND.
  - It counts in SEND and WAIT_RX.
  - Reaching TIMEOUT_CYC-1 without an RX beat: set timeout and go to DONE.
- Abort:
  - From IDLE or DONE: no effect.
  - From WAIT_RX: go to DONE with aborted=1.
  - From SEND with m_tvalid=0 or the handshake occurring this cycle: go to DONE with aborted=1.
  - Otherwise set an internal pending flag and go to DONE after the current beat's handshake. tvalid is never withdrawn mid-beat.
- DONE: done=1, busy=0. pass = (err_count==0) && !timeout && !aborted && (rx_count==frame_len).
- Simultaneous start and abort in IDLE or DONE: abort wins and start is ignored.

## Timing
- All outputs are registered.
- Reset values: every output 0 except s_tready, which is 0 during reset and 1 from the first cycle after rst deasserts.
- Reset mid-run returns the FSM to IDLE in one cycle, drops m_tvalid, and clears all status.
- start_pulse at cycle N: busy=1 and m_tvalid=1 with tdata=seed at N+1.
- With m_tready=1 continuously, the TX frame occupies cycles N+1 .. N+frame_len.
- The final RX handshake at cycle M gives done=1, with pass valid, at M+1.
- err_count and rx_count update the cycle after the corresponding RX handshake.
- Counter arithmetic:
  - rx_idx and the TX index are LEN_W bits wide.
  - err_count saturates; it does not wrap.
  - Data comparison wraps mod 2^DATA_W.

## Structure
- Shared package axis_lb_pkg holds:
  - the state enum (IDLE/SEND/WAIT_RX/DONE)
  - default DATA_W, LEN_W and TIMEOUT_CYC constants
  - the err_count width constant (16)
- Natural sub-module: axis_lb_checker. It contains the RX compare, err_count and rx_count logic, and exports a last-beat-accepted strobe.
- FSM, TX generator and timeout counter stay in the top.
- The VIO edge-pulse conditioning is external and feeds start_pulse and abort_pulse.

## Test plan
- Ideal loopback: seed=0x1000, frame_len=8, m_tready=1 tied to s_* → TX 0x1000..0x1007 with tlast on the 8th beat; done=1, pass=1, err_count=0, rx_count=8.
- Corrupt RX beat 3: XOR 0x1 into s_tdata, frame_len=4 → err_count=1, pass=0, rx_count=4.
- Backpressure: random m_tready, 50% duty, frame_len=16, seed=0xFFFFFFFC → tdata stable while stalled; data wraps to 0x00000000 at beat 4; pass=1.
- No return path: s_tvalid=0, TIMEOUT_CYC=100, frame_len=2 → timeout=1, done=1, pass=0, rx_count=0.
- Abort during SEND with m_tready=0: tvalid is held until m_tready=1 for one beat, then aborted=1, done=1. A start in the same cycle as that abort is ignored.
- Edge cases:
  - start with frame_len=0 → stays IDLE, busy=0.
  - start while busy → ignored.
  - rst asserted mid-frame → all outputs 0 the next cycle.
